mem_rd_collect: RTL and testbench
=================================

MEM_RD_COLLECT -- requirements
Module: mem_rd_collect

Interface
- REQ-001: Parameter SYS_ROW, default 16: number of accumulator banks / systolic input lanes.
- REQ-002: Parameter SYS_COL, default 16: systolic column count.
- REQ-003: Parameter DATA_WIDTH, default 16: element width and num_row width.
- REQ-004: Parameter ACCUM_SIZE, default 4096: accumulator entries. Derived ACCUM_ROW = ACCUM_SIZE/SYS_COL; CNT_W = $clog2(ACCUM_ROW)+1.
- REQ-005: clk  in  1  clock; all state updates on rising edge.
- REQ-006: rstn  in  1  reset, synchronous, active-low.
- REQ-007: start  in  1  one-cycle pulse; issued in the same cycle as the upstream read-controller kick-off.
- REQ-008: num_row  in  DATA_WIDTH  rows per lane for this transfer; sampled only when start is accepted.
- REQ-009: in_valid  in  SYS_ROW  per-lane read-data valid; lane i is skewed one cycle behind lane i-1.
- REQ-010: in_data  in  SYS_ROW x DATA_WIDTH  per-lane bank read data.
- REQ-011: out_valid  out  SYS_ROW  per-lane valid to systolic array.
- REQ-012: out_data  out  SYS_ROW x DATA_WIDTH  per-lane data to systolic array.
- REQ-013: busy  out  1  high in ACTIVE.
- REQ-014: done  out  1  one-cycle completion pulse.
- REQ-015: err  out  1  sticky protocol-error flag.

Function
- REQ-016: The FSM SHALL have two states, IDLE and ACTIVE.
- REQ-017: In IDLE, start SHALL latch eff_rows = min(num_row, ACCUM_ROW), clear all lane counters and err, and move to ACTIVE; if eff_rows==0, done SHALL pulse next cycle and the FSM SHALL stay IDLE.
- REQ-018: In ACTIVE, lane counter cnt[i] SHALL increment by 1 on each accepted in_valid[i].
- REQ-019: in_valid[i] SHALL be accepted only in ACTIVE with cnt[i] < eff_rows; otherwise the beat SHALL be dropped (no out_valid) and err set.
- REQ-020: Skew check: a beat on lane i>0 making cnt[i] > cnt[i-1] SHALL set err; the beat is still forwarded.
- REQ-021: Accepted beats SHALL appear on out_valid[i]/out_data[i] exactly 1 cycle later (pass-through mode); out_data holds its last value when out_valid is low.
- REQ-022: Completion: in the cycle T where all cnt[i]==eff_rows (incl. same-cycle final beats), the FSM SHALL return to IDLE and done SHALL pulse at T+1.
- REQ-023: start in ACTIVE SHALL be ignored and SHALL set err.
- REQ-024: Simultaneous final beat and start: start SHALL be treated as arriving in ACTIVE (ignored, err set).
- REQ-025: Counters SHALL be CNT_W wide and never wrap; they saturate at eff_rows.

Reset
- REQ-026: With rstn low at a clock edge: FSM=IDLE, counters=0, eff_rows=0, out_valid=0, out_data=0, busy=0, done=0, err=0, and all delay-line stages cleared.
- REQ-027: Reset mid-transfer SHALL abort without done; in_valid beats during reset SHALL be dropped without setting err.

Configuration
- REQ-028: Macro MEM_RD_COLLECT_DESKEW_EN: when defined, lane i SHALL be delayed by an additional SYS_ROW-1-i cycles so the k-th beat of every lane leaves in the same cycle (lane i latency = SYS_ROW-i); done timing per REQ-022 unchanged.
- REQ-029: When MEM_RD_COLLECT_DESKEW_EN is undefined, no delay lines SHALL exist and all lanes have latency 1.

Verification
- REQ-030: Skewed transfer, num_row=8, lane i valid cycles i+1..i+8 -> 8 out_valid beats per lane at latency 1, done once at cycle 24 (T=23), err=0.
- REQ-031: num_row=0xFFFF -> eff_rows=256; 256 beats per lane accepted, extra 257th beat on lane 0 dropped, err=1.
- REQ-032: num_row=0 -> no ACTIVE, busy stays 0, done pulses the cycle after start.
- REQ-033: Lane 3 valid one cycle before lane 2 on first beat -> err=1, data still forwarded; next start clears err.
- REQ-034: rstn low at mid-transfer beat 4 of 8 -> all outputs 0 next cycle, no done; new start then completes normally.
- REQ-035: MEM_RD_COLLECT_DESKEW_EN defined, num_row=4, data=lane index*16+beat -> each output cycle carries the same beat on all 16 lanes, first aligned cycle 16 cycles after lane-0 first valid.

Source files
------------

// File: rtl/mem_rd_collect.sv
// ---------------------------------------------------------------------------
// mem_rd_collect
// Collects per-lane accumulator bank read data and forwards it to the systolic
// array input lanes. Each lane's beat count is tracked against the transfer
// length. Lanes are expected to arrive skewed, with lane i one cycle behind
// lane i-1. The block detects protocol errors and pulses done once every lane
// has delivered its rows.
//
// Ports
//   clk          clock, all state on rising edge
//   rstn         synchronous active-low reset
//   i_start      one-cycle transfer kick-off
//   i_num_row    rows per lane, sampled when i_start is taken in IDLE
//   i_in_valid   per-lane read-data valid
//   i_in_data    per-lane read data
//   o_out_valid  per-lane valid towards the systolic array
//   o_out_data   per-lane data towards the systolic array (holds when idle)
//   o_busy       high while a transfer is active
//   o_done       one-cycle completion pulse
//   o_err        sticky protocol error, cleared by the next accepted start
//
// Build option
//   MEM_RD_COLLECT_DESKEW_EN : when defined, lane i gets SYS_ROW-1-i extra
//   delay stages so the k-th beat of every lane leaves in the same cycle.
// ---------------------------------------------------------------------------
module mem_rd_collect #(
  parameter int SYS_ROW    = 16,
  parameter int SYS_COL    = 16,
  parameter int DATA_WIDTH = 16,
  parameter int ACCUM_SIZE = 4096
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               i_start,
  input  logic [DATA_WIDTH-1:0]              i_num_row,
  input  logic [SYS_ROW-1:0]                 i_in_valid,
  input  logic [SYS_ROW-1:0][DATA_WIDTH-1:0] i_in_data,
  output logic [SYS_ROW-1:0]                 o_out_valid,
  output logic [SYS_ROW-1:0][DATA_WIDTH-1:0] o_out_data,
  output logic                               o_busy,
  output logic                               o_done,
  output logic                               o_err
);

  localparam int ACCUM_ROW = ACCUM_SIZE / SYS_COL;
  localparam int CNT_W     = $clog2(ACCUM_ROW) + 1;
  localparam logic [31:0] ACCUM_ROW_U = 32'(ACCUM_ROW);

  typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

  state_t                         r_state, w_state_next;
  logic [CNT_W-1:0]               r_eff_rows, w_eff_rows_next;
  logic [SYS_ROW-1:0][CNT_W-1:0]  r_cnt, w_cnt_next;
  logic [SYS_ROW-1:0]             w_accept, w_drop, w_skew_err, w_lane_full;
  logic                           w_all_done, w_clear, w_start_err, w_done_next, w_err_next;
  logic [31:0]                    w_num_ext;
  logic [CNT_W-1:0]               w_num_clamp;
  logic                           r_done, r_err;
  logic [SYS_ROW-1:0]             r_v1;
  logic [SYS_ROW-1:0][DATA_WIDTH-1:0] r_d1;

  // eff_rows = min(num_row, ACCUM_ROW); compare at 32 bits so a wide
  // num_row cannot alias onto a small count after truncation.
  assign w_num_ext   = 32'(i_num_row);
  assign w_num_clamp = (w_num_ext > ACCUM_ROW_U) ? CNT_W'(ACCUM_ROW) : CNT_W'(i_num_row);

  genvar gi;
  generate
    for (gi = 0; gi < SYS_ROW; gi++) begin : g_lane
      // A beat is taken only while active and short of the target; this is
      // also what keeps the counter from ever exceeding eff_rows.
      assign w_accept[gi]    = i_in_valid[gi] && (r_state == S_ACTIVE) && (r_cnt[gi] < r_eff_rows);
      assign w_drop[gi]      = i_in_valid[gi] && !w_accept[gi];
      assign w_cnt_next[gi]  = r_cnt[gi] + CNT_W'(w_accept[gi]);
      assign w_lane_full[gi] = (w_cnt_next[gi] == r_eff_rows);
      if (gi == 0) begin : g_first
        assign w_skew_err[gi] = 1'b0;
      end else begin : g_rest
        // Lane gi would overtake lane gi-1's registered count: it arrived
        // no later than its predecessor.
        assign w_skew_err[gi] = w_accept[gi] && (r_cnt[gi] >= r_cnt[gi-1]);
      end
    end
  endgenerate

  assign w_all_done = &w_lane_full;

  always_comb begin
    w_state_next    = r_state;
    w_eff_rows_next = r_eff_rows;
    w_clear         = 1'b0;
    w_start_err     = 1'b0;
    w_done_next     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_eff_rows_next = w_num_clamp;
          w_clear         = 1'b1;
          if (w_num_clamp == '0) w_done_next  = 1'b1;
          else                   w_state_next = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        // A start that lands on the final-beat cycle is still seen as
        // arriving mid-transfer.
        if (i_start) w_start_err = 1'b1;
        if (w_all_done) begin
          w_state_next = S_IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
    // A protocol error in the start cycle outranks the clear from start.
    if ((|w_drop) || (|w_skew_err) || w_start_err) w_err_next = 1'b1;
    else if (w_clear)                              w_err_next = 1'b0;
    else                                           w_err_next = r_err;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_eff_rows <= '0;
      r_cnt      <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_v1       <= '0;
      r_d1       <= '0;
    end else begin
      r_state    <= w_state_next;
      r_eff_rows <= w_eff_rows_next;
      r_cnt      <= w_clear ? '0 : w_cnt_next;
      r_done     <= w_done_next;
      r_err      <= w_err_next;
      r_v1       <= w_accept;
      for (int i = 0; i < SYS_ROW; i++) begin
        if (w_accept[i]) r_d1[i] <= i_in_data[i];
      end
    end
  end

  assign o_busy = (r_state == S_ACTIVE);
  assign o_done = r_done;
  assign o_err  = r_err;

`ifdef MEM_RD_COLLECT_DESKEW_EN
  // Lane gi already has one register of latency; add SYS_ROW-1-gi more so
  // every lane's total latency is SYS_ROW-gi and the skew is cancelled.
  generate
    for (gi = 0; gi < SYS_ROW; gi++) begin : g_dly
      localparam int DLY = SYS_ROW - 1 - gi;
      if (DLY == 0) begin : g_none
        assign o_out_valid[gi] = r_v1[gi];
        assign o_out_data[gi]  = r_d1[gi];
      end else begin : g_line
        logic [DLY-1:0]                 r_dl_v;
        logic [DLY-1:0][DATA_WIDTH-1:0] r_dl_d;
        always_ff @(posedge clk) begin
          if (!rstn) begin
            r_dl_v <= '0;
            r_dl_d <= '0;
          end else begin
            r_dl_v[0] <= r_v1[gi];
            if (r_v1[gi]) r_dl_d[0] <= r_d1[gi];
            for (int j = 1; j < DLY; j++) begin
              r_dl_v[j] <= r_dl_v[j-1];
              if (r_dl_v[j-1]) r_dl_d[j] <= r_dl_d[j-1];
            end
          end
        end
        assign o_out_valid[gi] = r_dl_v[DLY-1];
        assign o_out_data[gi]  = r_dl_d[DLY-1];
      end
    end
  endgenerate
`else
  assign o_out_valid = r_v1;
  assign o_out_data  = r_d1;
`endif

endmodule

// File: tb/tb_mem_rd_collect.sv
// ---------------------------------------------------------------------------
// tb_mem_rd_collect
// Randomised self-checking bench for mem_rd_collect. A driver applies one
// cycle of stimulus at a time and runs a behavioural model (integer counts,
// queues) that pushes expected beats, done pulses and busy/err states into
// scoreboards. An independent monitor pops and compares each clock.
// ---------------------------------------------------------------------------
module tb_mem_rd_collect;

  localparam int SYS_ROW    = 16;
  localparam int SYS_COL    = 16;
  localparam int DATA_WIDTH = 16;
  localparam int ACCUM_SIZE = 4096;
  localparam int ACCUM_ROW  = ACCUM_SIZE / SYS_COL;

  typedef logic [SYS_ROW-1:0][DATA_WIDTH-1:0] data_t;

  typedef struct {
    int                    lane;
    int                    due;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  typedef struct {
    int at;
    bit busy;
    bit err;
    bit rst;
  } state_exp_t;

  logic                 clk;
  logic                 rstn;
  logic                 i_start;
  logic [DATA_WIDTH-1:0] i_num_row;
  logic [SYS_ROW-1:0]   i_in_valid;
  data_t                i_in_data;
  logic [SYS_ROW-1:0]   o_out_valid;
  data_t                o_out_data;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_err;

  mem_rd_collect #(
    .SYS_ROW   (SYS_ROW),
    .SYS_COL   (SYS_COL),
    .DATA_WIDTH(DATA_WIDTH),
    .ACCUM_SIZE(ACCUM_SIZE)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .i_start    (i_start),
    .i_num_row  (i_num_row),
    .i_in_valid (i_in_valid),
    .i_in_data  (i_in_data),
    .o_out_valid(o_out_valid),
    .o_out_data (o_out_data),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_err      (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int edge_cnt = 0;

  beat_t      sbq[$];
  int         done_q[$];
  state_exp_t st_q[$];

  // reference model state
  bit m_active = 0;
  int m_eff    = 0;
  int m_cnt[SYS_ROW];
  bit m_err    = 0;

  // monitor observations used by directed checks
  int last_done_edge = -1;
  bit busy_seen      = 0;
  int obs_beats[SYS_ROW];
  int x_start_edge   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", nm, edge_cnt, act, exp);
    end
  endtask

  function automatic int lane_lat(input int i);
`ifdef MEM_RD_COLLECT_DESKEW_EN
    return SYS_ROW - i;
`else
    return 1 + 0 * i;
`endif
  endfunction

  // Apply one cycle of inputs, predict the effect of the edge that samples
  // them, then advance to 2 time units after that edge.
  task automatic drive_cycle(input bit rv, input bit sv, input logic [DATA_WIDTH-1:0] nv,
                             input logic [SYS_ROW-1:0] vv, input data_t dv);
    int nxt;
    bit set_err;
    bit clr;
    bit all_full;
    int old[SYS_ROW];
    state_exp_t e;
    nxt = edge_cnt + 1;
    rstn = rv; i_start = sv; i_num_row = nv; i_in_valid = vv; i_in_data = dv;
    if (!rv) begin
      m_active = 0; m_eff = 0; m_err = 0;
      for (int i = 0; i < SYS_ROW; i++) m_cnt[i] = 0;
      for (int j = sbq.size() - 1; j >= 0; j--) if (sbq[j].due >= nxt) sbq.delete(j);
      for (int j = done_q.size() - 1; j >= 0; j--) if (done_q[j] >= nxt) done_q.delete(j);
      e.at = nxt; e.busy = 0; e.err = 0; e.rst = 1;
      st_q.push_back(e);
    end else begin
      set_err = 0; clr = 0;
      old = m_cnt;
      if (m_active) begin
        if (sv) set_err = 1;
        for (int i = 0; i < SYS_ROW; i++) begin
          if (vv[i]) begin
            if (m_cnt[i] < m_eff) begin
              if (i > 0 && old[i] + 1 > old[i-1]) set_err = 1;
              m_cnt[i]++;
              sbq.push_back('{lane: i, due: edge_cnt + lane_lat(i), data: dv[i]});
            end else begin
              set_err = 1;
            end
          end
        end
        all_full = 1;
        for (int i = 0; i < SYS_ROW; i++) if (m_cnt[i] != m_eff) all_full = 0;
        if (all_full) begin
          m_active = 0;
          done_q.push_back(nxt);
        end
      end else begin
        if (vv != '0) set_err = 1;
        if (sv) begin
          m_eff = (int'(nv) > ACCUM_ROW) ? ACCUM_ROW : int'(nv);
          for (int i = 0; i < SYS_ROW; i++) m_cnt[i] = 0;
          clr = 1;
          if (m_eff == 0) done_q.push_back(nxt);
          else            m_active = 1;
        end
      end
      if (set_err)  m_err = 1;
      else if (clr) m_err = 0;
      e.at = nxt; e.busy = m_active; e.err = m_err; e.rst = 0;
      st_q.push_back(e);
    end
    @(posedge clk);
    #2;
  endtask

  function automatic data_t rand_data();
    data_t d;
    for (int i = 0; i < SYS_ROW; i++) d[i] = DATA_WIDTH'($urandom);
    return d;
  endfunction

  // One transfer: start at relative cycle 0, lane i's k-th beat at i+slot[k].
  // early_lane shifts that lane's first beat one cycle earlier; extra0 adds a
  // surplus beat on lane 0; rst_cyc asserts reset for one cycle and stops the
  // lane traffic; start_cyc injects a second start (-2 = final beat cycle).
  task automatic xfer(input logic [DATA_WIDTH-1:0] nr, input int gap_max, input int early_lane,
                      input bit extra0, input int rst_cyc, input int start_cyc, input bit pat);
    int eff;
    int slot[$];
    int nb[SYS_ROW];
    int t;
    int fin;
    int last;
    int scyc;
    int when;
    bit aborted;
    bit rv;
    logic [SYS_ROW-1:0] vv;
    data_t dv;
    eff = (int'(nr) > ACCUM_ROW) ? ACCUM_ROW : int'(nr);
    t = 0;
    for (int k = 0; k < eff; k++) begin
      t += 1;
      if (gap_max > 0 && $urandom_range(99, 0) < 25) t += $urandom_range(gap_max, 1);
      slot.push_back(t);
    end
    for (int i = 0; i < SYS_ROW; i++) nb[i] = 0;
    fin  = (eff > 0) ? SYS_ROW - 1 + slot[eff-1] : 0;
    scyc = (start_cyc == -2) ? fin : start_cyc;
    last = fin + 3;
    x_start_edge = edge_cnt + 1;
    drive_cycle(1'b1, 1'b1, nr, '0, rand_data());
    aborted = 0;
    for (int c = 1; c <= last; c++) begin
      vv = '0;
      dv = rand_data();
      if (!aborted) begin
        for (int i = 0; i < SYS_ROW; i++) begin
          if (nb[i] < eff) begin
            when = i + slot[nb[i]];
            if (i == early_lane && nb[i] == 0) when -= 1;
            if (when == c) begin
              vv[i] = 1'b1;
              if (pat) dv[i] = DATA_WIDTH'(i * 16 + nb[i]);
              nb[i]++;
            end
          end
        end
        if (extra0 && eff > 0 && c == slot[eff-1] + 1) vv[0] = 1'b1;
      end
      rv = (c != rst_cyc);
      drive_cycle(rv, (c == scyc) && !aborted, nr, vv, dv);
      if (!rv) aborted = 1;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive_cycle(1'b1, 1'b0, '0, '0, rand_data());
  endtask

  // Monitor / scoreboard checker
  initial begin
    state_exp_t e;
    bit exp_done;
    int idx;
    forever begin
      @(posedge clk);
      #1;
      edge_cnt++;
      if (st_q.size() > 0 && st_q[0].at == edge_cnt) begin
        e = st_q.pop_front();
        chk("busy", longint'(o_busy), longint'(e.busy));
        chk("err", longint'(o_err), longint'(e.err));
        if (e.rst) begin
          chk("rst_out_valid", longint'(o_out_valid), 0);
          chk("rst_out_data_nz", longint'(|o_out_data), 0);
          chk("rst_done", longint'(o_done), 0);
        end
      end
      if (o_busy) busy_seen = 1;
      if (o_done) last_done_edge = edge_cnt;
      exp_done = (done_q.size() > 0 && done_q[0] == edge_cnt);
      if (exp_done) void'(done_q.pop_front());
      chk("done", longint'(o_done), longint'(exp_done));
      for (int i = 0; i < SYS_ROW; i++) begin
        idx = -1;
        for (int j = 0; j < sbq.size(); j++) begin
          if (sbq[j].lane == i) begin
            idx = j;
            break;
          end
        end
        if (o_out_valid[i]) begin
          obs_beats[i]++;
          if (idx < 0) begin
            chk($sformatf("lane%0d_unexpected_valid", i), 1, 0);
          end else begin
            chk($sformatf("lane%0d_due", i), longint'(edge_cnt), longint'(sbq[idx].due));
            chk($sformatf("lane%0d_data", i), longint'(o_out_data[i]), longint'(sbq[idx].data));
            sbq.delete(idx);
          end
        end else if (idx >= 0 && sbq[idx].due <= edge_cnt) begin
          chk($sformatf("lane%0d_missing_valid", i), 0, 1);
          sbq.delete(idx);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < SYS_ROW; i++) begin
      m_cnt[i] = 0;
      obs_beats[i] = 0;
    end
    rstn = 1'b0; i_start = 1'b0; i_num_row = '0; i_in_valid = '0; i_in_data = '0;
    for (int k = 0; k < 3; k++) drive_cycle(1'b0, 1'b0, '0, '0, '0);
    idle(2);

    // 8-row skewed transfer: done visible in cycle 24 after start
    last_done_edge = -1;
    xfer(16'd8, 0, -1, 0, -1, -1, 0);
    chk("done_time_8rows", longint'(last_done_edge), longint'(x_start_edge + 23));
    chk("err_after_clean", longint'(o_err), 0);
    idle(2);

    // zero rows: done the cycle after start, never busy
    last_done_edge = -1;
    busy_seen = 0;
    xfer(16'd0, 0, -1, 0, -1, -1, 0);
    chk("done_time_zero", longint'(last_done_edge), longint'(x_start_edge));
    chk("busy_seen_zero", longint'(busy_seen), 0);
    idle(2);

    // randomised lengths and gaps
    for (int r = 0; r < 6; r++) begin
      xfer(DATA_WIDTH'($urandom_range(12, 1)), 3, -1, 0, -1, -1, 0);
      idle($urandom_range(3, 0));
    end

    // clamp to ACCUM_ROW with one surplus beat on lane 0
    for (int i = 0; i < SYS_ROW; i++) obs_beats[i] = 0;
    xfer(16'hFFFF, 0, -1, 1, -1, -1, 0);
    chk("clamp_beats_lane0", longint'(obs_beats[0]), longint'(ACCUM_ROW));
    chk("clamp_beats_lane15", longint'(obs_beats[SYS_ROW-1]), longint'(ACCUM_ROW));
    chk("clamp_err", longint'(o_err), 1);
    idle(2);

    // lane 3 early by one cycle: error but data forwarded; next start clears
    xfer(16'd4, 0, 3, 0, -1, -1, 0);
    chk("skew_err", longint'(o_err), 1);
    xfer(16'd4, 0, -1, 0, -1, -1, 0);
    chk("skew_err_cleared", longint'(o_err), 0);
    idle(2);

    // reset at beat 4 of 8: no done, then a clean transfer
    last_done_edge = -1;
    xfer(16'd8, 0, -1, 0, 4, -1, 0);
    chk("no_done_after_abort", longint'(last_done_edge), -1);
    xfer(16'd8, 0, -1, 0, -1, -1, 0);
    chk("done_time_after_abort", longint'(last_done_edge), longint'(x_start_edge + 23));
    idle(2);

    // start while active, and start together with the final beat
    xfer(16'd6, 2, -1, 0, -1, 3, 0);
    chk("start_active_err", longint'(o_err), 1);
    xfer(16'd5, 0, -1, 0, -1, -1, 0);
    xfer(16'd5, 2, -1, 0, -1, -2, 0);
    chk("start_final_beat_err", longint'(o_err), 1);
    idle(2);

    // lane*16+beat pattern (aligned across lanes when deskew is built in)
    xfer(16'd4, 0, -1, 0, -1, -1, 1);
    idle(SYS_ROW + 4);

    chk("beats_left_in_scoreboard", longint'(sbq.size()), 0);
    chk("done_left_in_scoreboard", longint'(done_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
